// File: rtl/cic_ctrl_pkg.sv
// rtl/cic_ctrl_pkg.sv - shared types and defaults for the CIC sample controller
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam int DEFAULT_SETTLE_SAMPLES = 3;
  localparam int DEFAULT_FIFO_DEPTH     = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cic_sample_fifo.sv
// rtl/cic_sample_fifo.sv - first-word-fall-through sample buffer with synchronous flush
module cic_sample_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             one_left
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      level;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign one_left = (level == (AW+1)'(1));

  // A push into a full buffer only lands when the head leaves on the same edge.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cic_sample_ctrl.sv
// rtl/cic_sample_ctrl.sv - CIC decimator sequencing: clear/release, settle discard, sample capture
module cic_sample_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int DECIMATION_FACTOR = 256,
  parameter int NUMBITS           = 3*$clog2(DECIMATION_FACTOR)+1,
  parameter int SETTLE_SAMPLES    = DEFAULT_SETTLE_SAMPLES,
  parameter int FIFO_DEPTH        = DEFAULT_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [15:0]        num_samples,
  input  logic [NUMBITS-1:0] cic_out,
  input  logic               cic_stb,
  output logic               cic_clear_n,
  output logic [NUMBITS-1:0] data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [15:0]        sample_count
);

  localparam int SW = $clog2(SETTLE_SAMPLES+1);

  state_t          state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [15:0]     count_d;
  logic [15:0]     num_q, num_d;
  logic            ovf_d;
  logic            clear_n_d;
  logic            done_d;
  logic            push;
  logic            pop;
  logic            flush;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_one_left;

  assign pop        = !fifo_empty && data_ready;
  assign data_valid = !fifo_empty;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    count_d  = sample_count;
    num_d    = num_q;
    ovf_d    = overflow;
    push     = 1'b0;
    flush    = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          flush    = 1'b1;
          ovf_d    = 1'b0;
          count_d  = '0;
          settle_d = '0;
          num_d    = num_samples;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (stop) begin
          state_d = DRAIN;
        end else if (cic_stb) begin
          settle_d = settle_q + 1'b1;
          if (settle_q == SW'(SETTLE_SAMPLES-1)) state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
        end else if (cic_stb) begin
          push    = 1'b1;
          count_d = sat_inc16(sample_count);
          if (fifo_full && !pop) ovf_d = 1'b1;
          if ((num_q != 16'd0) && (count_d == num_q)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the edge that removes the last entry so done lines up with busy falling.
        if (fifo_empty || (fifo_one_left && pop)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    clear_n_d = (state_d == SETTLE) || (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      sample_count <= '0;
      num_q        <= '0;
      overflow     <= 1'b0;
      cic_clear_n  <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      sample_count <= count_d;
      num_q        <= num_d;
      overflow     <= ovf_d;
      cic_clear_n  <= clear_n_d;
      done         <= done_d;
    end
  end

  cic_sample_fifo #(
    .WIDTH (NUMBITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .push     (push),
    .pop      (pop),
    .wdata    (cic_out),
    .rdata    (data_out),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .one_left (fifo_one_left)
  );

endmodule

// File: tb/tb_cic_sample_ctrl.sv
// tb/tb_cic_sample_ctrl.sv - self-checking bench for cic_sample_ctrl
module tb_cic_sample_ctrl;

  localparam int DEC    = 256;
  localparam int NB     = 25;
  localparam int SETTLE = 3;
  localparam int DEPTH  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   num_samples = '0;
  logic [NB-1:0] cic_out = '0;
  logic          cic_stb = 1'b0;
  logic          data_ready = 1'b0;
  logic          cic_clear_n;
  logic [NB-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [15:0]   sample_count;

  always #5 clk = ~clk;

  cic_sample_ctrl #(
    .DECIMATION_FACTOR (DEC),
    .NUMBITS           (NB),
    .SETTLE_SAMPLES    (SETTLE),
    .FIFO_DEPTH        (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .num_samples  (num_samples),
    .cic_out      (cic_out),
    .cic_stb      (cic_stb),
    .cic_clear_n  (cic_clear_n),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .sample_count (sample_count)
  );

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  logic [NB-1:0] delivered[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Acquisition model: phase, strobe counts and a queue standing in for the buffer.
  typedef enum {M_IDLE, M_SETTLE, M_RUN, M_DRAIN} phase_t;
  phase_t        m_phase = M_IDLE;
  phase_t        m_next;
  logic [NB-1:0] mq[$];
  int            m_settle = 0;
  int            m_cnt = 0;
  int            m_num = 0;
  int            m_size;
  bit            m_ovf = 0;
  bit            m_done = 0;
  bit            m_clear_n = 0;
  bit            m_pop;
  bit            m_push;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_phase = M_IDLE; m_settle = 0; m_cnt = 0; m_num = 0;
      m_ovf = 0; m_done = 0; m_clear_n = 0;
    end else begin
      m_pop  = (mq.size() != 0) && data_ready;
      m_push = 0;
      m_done = 0;
      m_next = m_phase;
      case (m_phase)
        M_IDLE: if (start && !stop) begin
          mq.delete(); m_ovf = 0; m_cnt = 0; m_settle = 0;
          m_num = int'(num_samples); m_next = M_SETTLE;
        end
        M_SETTLE: if (stop) m_next = M_DRAIN;
          else if (cic_stb) begin
            m_settle++;
            if (m_settle == SETTLE) m_next = M_RUN;
          end
        M_RUN: if (stop) m_next = M_DRAIN;
          else if (cic_stb) begin
            m_push = 1;
            if (m_cnt < 65535) m_cnt++;
            if (m_num != 0 && m_cnt == m_num) m_next = M_DRAIN;
          end
        M_DRAIN: if (mq.size() == 0 || (mq.size() == 1 && m_pop)) begin
          m_next = M_IDLE; m_done = 1;
        end
      endcase
      m_size = mq.size();
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (m_size < DEPTH || m_pop) mq.push_back(cic_out);
        else m_ovf = 1;
      end
      m_phase   = m_next;
      m_clear_n = (m_phase == M_SETTLE) || (m_phase == M_RUN);
    end
  end

  always @(negedge clk) begin
    chk("cic_clear_n", cic_clear_n, m_clear_n);
    chk("busy", busy, m_phase != M_IDLE);
    chk("done", done, m_done);
    chk("overflow", overflow, m_ovf);
    chk("sample_count", sample_count, m_cnt);
    chk("data_valid", data_valid, mq.size() != 0);
    chk("data_out", data_out, (mq.size() != 0) ? mq[0] : '0);
    if (done) done_count++;
  end

  always @(posedge clk) begin
    if (reset_n && data_valid && data_ready) delivered.push_back(data_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int val, input bit stp, input bit rdy_pulse);
    logic old_rdy;
    repeat (DEC-1) tick();
    old_rdy = data_ready;
    cic_out = NB'(val);
    cic_stb = 1'b1;
    stop    = stp;
    if (rdy_pulse) data_ready = 1'b1;
    tick();
    cic_stb    = 1'b0;
    stop       = 1'b0;
    data_ready = old_rdy;
  endtask

  task automatic run_start(input int n);
    num_samples = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && busy; i++) tick();
    chk("idle_timeout", busy, 0);
  endtask

  task automatic check_delivered(input string name, input int first, input int n);
    chk({name, "_len"}, delivered.size(), n);
    for (int i = 0; i < n && i < delivered.size(); i++)
      chk({name, "_val"}, delivered[i], first + i);
    delivered.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_clear_n", cic_clear_n, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", sample_count, 0);
    chk("rst_data", data_out, 0);
    reset_n = 1'b1;
    tick();

    // Fixed-count acquisition of 4, settling discards 10..12
    data_ready = 1'b1;
    done_count = 0;
    run_start(4);
    chk("t1_busy_rise", busy, 1);
    chk("t1_clear_rel", cic_clear_n, 1);
    for (int v = 10; v <= 20; v++) strobe(v, 0, 0);
    wait_idle();
    chk("t1_done_once", done_count, 1);
    chk("t1_count", sample_count, 4);
    chk("t1_ovf", overflow, 0);
    check_delivered("t1", 13, 4);

    // Continuous mode with a stalled consumer overflows the buffer
    data_ready = 1'b0;
    run_start(0);
    for (int v = 100; v < 103; v++) strobe(v, 0, 0);
    for (int v = 200; v < 206; v++) strobe(v, 0, 0);
    chk("t3_ovf", overflow, 1);
    chk("t3_count", sample_count, 6);
    chk("t3_head", data_out, 200);
    data_ready = 1'b1;
    repeat (6) tick();
    chk("t3_empty", data_valid, 0);
    check_delivered("t3", 200, 4);
    pulse_stop();
    wait_idle();

    // Stop coinciding with a RUN strobe
    data_ready = 1'b0;
    run_start(0);
    for (int v = 0; v < SETTLE; v++) strobe(v, 0, 0);
    strobe(300, 0, 0);
    strobe(301, 0, 0);
    strobe(302, 1, 0);
    chk("t4_clear_n", cic_clear_n, 0);
    chk("t4_busy", busy, 1);
    chk("t4_count", sample_count, 2);
    data_ready = 1'b1;
    wait_idle();
    check_delivered("t4", 300, 2);

    // start together with stop in IDLE is ignored
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("t5_busy", busy, 0);
    tick();
    chk("t5_busy2", busy, 0);
    chk("t5_clear_n", cic_clear_n, 0);

    // start during RUN does not relatch num_samples
    run_start(5);
    for (int v = 0; v < SETTLE; v++) strobe(v, 0, 0);
    strobe(403, 0, 0);
    run_start(2);
    for (int v = 404; v <= 407; v++) strobe(v, 0, 0);
    wait_idle();
    chk("t5_count", sample_count, 5);
    check_delivered("t5", 403, 5);

    // Full buffer with simultaneous push and pop across the wrap
    data_ready = 1'b0;
    run_start(0);
    for (int v = 0; v < SETTLE; v++) strobe(v, 0, 0);
    for (int v = 500; v <= 503; v++) strobe(v, 0, 0);
    chk("t6_full_head", data_out, 500);
    for (int v = 504; v <= 509; v++) strobe(v, 0, 1);
    chk("t6_ovf", overflow, 0);
    chk("t6_count", sample_count, 10);
    chk("t6_head", data_out, 506);
    data_ready = 1'b1;
    pulse_stop();
    wait_idle();
    check_delivered("t6", 500, 10);

    // Asynchronous reset mid-RUN, then a fresh acquisition settles again
    data_ready = 1'b0;
    run_start(0);
    for (int v = 0; v < SETTLE; v++) strobe(v, 0, 0);
    strobe(600, 0, 0);
    strobe(601, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_clear_n", cic_clear_n, 0);
    chk("t7_busy", busy, 0);
    chk("t7_valid", data_valid, 0);
    chk("t7_count", sample_count, 0);
    chk("t7_data", data_out, 0);
    tick();
    reset_n = 1'b1;
    delivered.delete();
    tick();
    run_start(0);
    for (int v = 700; v < 703; v++) strobe(v, 0, 0);
    chk("t7_settle_count", sample_count, 0);
    chk("t7_settle_valid", data_valid, 0);
    strobe(703, 0, 0);
    chk("t7_run_count", sample_count, 1);
    chk("t7_run_head", data_out, 703);
    data_ready = 1'b1;
    pulse_stop();
    wait_idle();
    check_delivered("t7", 703, 1);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_sample_ctrl.md
# cic_sample_ctrl

Sequencing controller for the third-order CIC decimator. It holds the filter in clear while idle and releases it on a start command. It discards the settling outputs, then captures each decimated sample into a small FIFO. Samples leave through a valid/ready interface toward the register/readout logic, in continuous or fixed-count acquisitions.

## Interface
Parameters:
- DECIMATION_FACTOR, 256, CIC decimation ratio; used only for the strobe-spacing check
- NUMBITS, 3*$clog2(DECIMATION_FACTOR)+1, CIC output width (25 at default)
- SETTLE_SAMPLES, 3, CIC outputs discarded after release (= filter order)
- FIFO_DEPTH, 4, sample buffer depth; power of 2, ≥2

Ports:
- clk  in  1  modulator-rate clock, same clock as the CIC integrators
- reset_n  in  1  reset reset_n, asynchronous, active-low; clock clk
- start  in  1  one-cycle acquisition start pulse
- stop  in  1  one-cycle abort/finish pulse
- num_samples  in  16  samples to deliver; 0 = continuous; sampled on accepted start
- cic_out  in  NUMBITS  CIC output register
- cic_stb  in  1  one-cycle pulse, synchronous to clk, when cic_out has updated and is stable
- cic_clear_n  out  1  registered active-low clear to CIC; reset value 0
- data_out  out  NUMBITS  FIFO head; reset value 0
- data_valid  out  1  head valid; reset value 0
- data_ready  in  1  consumer accepts head when data_valid & data_ready
- busy  out  1  state ≠ IDLE; reset value 0
- done  out  1  one-cycle pulse on return to IDLE; reset value 0
- overflow  out  1  sticky: a sample was dropped on a full FIFO; reset value 0
- sample_count  out  16  samples pushed this acquisition; reset value 0

## Operation
- States: IDLE, SETTLE, RUN, DRAIN.
- IDLE:
  - cic_clear_n=0.
  - On start: clear overflow, sample_count, settle counter and FIFO; latch num_samples; go to SETTLE.
- SETTLE:
  - cic_clear_n=1.
  - Each cic_stb increments the settle counter; cic_out is ignored.
  - On the SETTLE_SAMPLES-th strobe go to RUN. That strobe is not pushed.
- RUN:
  - Each cic_stb pushes cic_out and increments sample_count.
  - When num_samples≠0 and the push brings sample_count to num_samples, go to DRAIN.
- DRAIN:
  - No pushes; cic_clear_n=0.
  - Go to IDLE with done=1 for one cycle in the cycle the FIFO becomes empty (or immediately if already empty).
- stop in SETTLE or RUN goes to DRAIN; a strobe in the same cycle is not pushed. stop in IDLE or DRAIN is ignored.
- start and stop in the same cycle: stop wins; a start is ignored in any non-IDLE state.
- Full FIFO on a push:
  - Sample is dropped, overflow set, sample_count still incremented.
  - A push and a pop in the same cycle with the FIFO full both succeed, with no overflow.
- Pop when data_valid & data_ready. data_valid and data_out are held stable until accepted.
- sample_count saturates at 16'hFFFF in continuous mode.
- Asynchronous reset mid-acquisition returns everything to its reset values; FIFO contents are lost.

## Timing
- cic_clear_n is registered: it deasserts the cycle after start and asserts the cycle after the state enters DRAIN or IDLE.
- FIFO is first-word-fall-through: a push at edge t into an empty FIFO gives data_valid=1 from t+1.
- The pop and push pointers update on the same edge. A pop at t exposes the next entry at t+1.
- done coincides with the cycle busy falls. busy rises the cycle after start.
- cic_stb spacing is ≥DECIMATION_FACTOR clk. Behaviour with closer strobes is unspecified but must not corrupt the FIFO pointers.

## Structure
- Package cic_ctrl_pkg: state enum type (IDLE, SETTLE, RUN, DRAIN, 2-bit), default SETTLE_SAMPLES, default FIFO_DEPTH.
- Sub-module cic_sample_fifo (parameters WIDTH, DEPTH):
  - Ports: push, pop, wdata, rdata, full, empty, flush.
  - Synchronous flush, asynchronous reset.
- Top holds the FSM, counters, overflow flag and output registers.

## Test plan
- Reset, then start with num_samples=4 and cic_stb every 256 cycles carrying values 10..20, data_ready=1:
  - values 10, 11, 12 are discarded;
  - 13, 14, 15, 16 are delivered;
  - done pulses once; sample_count=4; overflow=0.
- Continuous mode (num_samples=0) with data_ready=0 for 6 strobes after settling:
  - FIFO holds the first 4 samples;
  - overflow=1; sample_count=6;
  - raising data_ready drains exactly those 4 values in order.
- stop asserted in the same cycle as a RUN strobe:
  - that sample is not pushed;
  - DRAIN empties the remaining entries, then done;
  - cic_clear_n=0 from the following cycle.
- start and stop together in IDLE: state stays IDLE, busy=0.
  - A start during RUN is ignored and num_samples is not relatched.
- Full FIFO with simultaneous push and pop: no overflow; ordering is preserved across the 4-entry wrap-around.
- reset_n pulsed low mid-RUN:
  - all outputs return to reset values asynchronously; cic_clear_n=0;
  - a new start performs a full SETTLE again.
